// File: rtl/rca_byte_serial_ctrl.sv
// Wide unsigned adder built from one shared 8-bit ripple adder, one byte per clock, LSB first.
// Latency: out_valid rises NBYTES cycles after the accept edge. Backpressure: result held in DONE until out_ready.

module rca_2op_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [8:0] s_o
);
  logic c;

  always_comb begin
    c   = cin_i;
    s_o = '0;
    for (int i = 0; i < 8; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    s_o[8] = c;
  end
endmodule

module rca_byte_serial_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] a_in,
  input  logic [8*NBYTES-1:0] b_in,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES:0]   sum_out,
  output logic                busy
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic          carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W:0]    sum_q, sum_d;
  logic [8:0]    s;

  rca_2op_8bit u_add (
    .a_i   (a_sh_q[7:0]),
    .b_i   (b_sh_q[7:0]),
    .cin_i (carry_q),
    .s_o   (s)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) sum_d[8*i +: 8] = s[7:0];
        end
        carry_d = s[8];
        a_sh_d  = a_sh_q >> 8;
        b_sh_d  = b_sh_q >> 8;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NBYTES - 1)) begin
          sum_d[W] = s[8];
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum_out   = sum_q;
endmodule
